keccak_perm_ctrl: RTL and testbench

Sequential Keccak-f[1600] permutation engine. Accepts a 1600-bit state over a valid/ready handshake and iterates the 24 rounds through chained `keccak_round` instances. It generates the compact 7-bit round constant for each round itself and returns the permuted state over a second valid/ready handshake. It drives the round datapath and is the block the sponge (absorb/squeeze) logic talks to.

---
 rtl/keccak_globals.sv | 52 +++++
 rtl/keccak_rc_rom.sv | 16 +
 rtl/keccak_round.sv | 53 +++++
 rtl/keccak_perm_ctrl.sv | 108 ++++++++++
 tb/tb_keccak_perm_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keccak_globals.sv
// Shared Keccak-f[1600] types, constants and small helpers.
//   k_plane      : five 64-bit lanes, indexed [x][bit]
//   k_state      : five planes, indexed [y][x][bit]
//   ctrl_state_e : permutation controller FSM encoding
//   RC_TABLE     : compact 7-bit round constants, round 0..23
//   RHO          : rotation offsets, indexed [x][y]
package keccak_globals;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned NUM_ROUNDS = 24;
    localparam int unsigned RC_WIDTH   = 7;
    localparam int unsigned CNT_W      = 5;

    typedef logic [4:0][LANE_W-1:0] k_plane;
    typedef k_plane [4:0]            k_state;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ctrl_state_e;

    // Bit j of an entry maps to lane[0][0] bit 2^j-1.
    localparam logic [RC_WIDTH-1:0] RC_TABLE [NUM_ROUNDS] = '{
        7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
        7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
        7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
    };

    localparam int unsigned RHO [5][5] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    function automatic logic [LANE_W-1:0] rotl64(input logic [LANE_W-1:0] v,
                                                 input int unsigned      n);
        if (n == 0) return v;
        return (v << n) | (v >> (LANE_W - n));
    endfunction

    // Spread the compact round constant onto its lane bit positions.
    function automatic logic [LANE_W-1:0] rc_expand(input logic [RC_WIDTH-1:0] rc);
        logic [LANE_W-1:0] lane;
        lane = '0;
        for (int j = 0; j < int'(RC_WIDTH); j++) lane[(1 << j) - 1] = rc[j];
        return lane;
    endfunction

endpackage

// File: rtl/keccak_rc_rom.sv
// Round-constant lookup.
//   idx_i : round index (0..31)
//   rc_o  : compact 7-bit round constant, 0 for indices 24..31
module keccak_rc_rom
    import keccak_globals::*;
(
    input  logic [CNT_W-1:0]    idx_i,
    output logic [RC_WIDTH-1:0] rc_o
);

    always_comb begin
        rc_o = '0;
        if (idx_i < CNT_W'(NUM_ROUNDS)) rc_o = RC_TABLE[idx_i];
    end

endmodule

// File: rtl/keccak_round.sv
// One combinational Keccak-f[1600] round: theta, rho, pi, chi, iota.
//   state_i : state entering the round
//   rc_i    : compact round constant for this round
//   state_o : state leaving the round
module keccak_round
    import keccak_globals::*;
(
    input  k_state              state_i,
    input  logic [RC_WIDTH-1:0] rc_i,
    output k_state              state_o
);

    k_plane col_par;
    k_plane col_mix;
    k_state theta;
    k_state rho_pi;

    always_comb begin
        col_par = '0;
        col_mix = '0;
        theta   = '0;
        rho_pi  = '0;
        state_o = '0;

        for (int x = 0; x < 5; x++) begin
            col_par[x] = state_i[0][x] ^ state_i[1][x] ^ state_i[2][x]
                       ^ state_i[3][x] ^ state_i[4][x];
        end
        for (int x = 0; x < 5; x++) begin
            col_mix[x] = col_par[(x + 4) % 5] ^ rotl64(col_par[(x + 1) % 5], 1);
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) theta[y][x] = state_i[y][x] ^ col_mix[x];
        end

        // Lane (x,y) is rotated and moved to (y, 2x+3y).
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                rho_pi[(2 * x + 3 * y) % 5][y] = rotl64(theta[y][x], RHO[x][y]);
            end
        end

        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                state_o[y][x] = rho_pi[y][x]
                              ^ (~rho_pi[y][(x + 1) % 5] & rho_pi[y][(x + 2) % 5]);
            end
        end

        state_o[0][0] = state_o[0][0] ^ rc_expand(rc_i);
    end

endmodule

// File: rtl/keccak_perm_ctrl.sv
// Sequential Keccak-f[1600] permutation engine, ROUNDS_PER_CYCLE rounds per clock.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : input state handshake, in_state_i is the state
//   out_valid_o / out_ready_i: result handshake, out_state_o is the state register
//   busy_o                   : permutation in progress
module keccak_perm_ctrl
    import keccak_globals::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   in_valid_i,
    output logic   in_ready_o,
    input  k_state in_state_i,
    output logic   out_valid_o,
    input  logic   out_ready_i,
    output k_state out_state_o,
    output logic   busy_o
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(ROUNDS_PER_CYCLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS);

    if ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rounds_per_cycle
        $error("ROUNDS_PER_CYCLE must divide the 24 Keccak rounds");
    end

    ctrl_state_e      state_q, state_d;
    k_state           perm_q, perm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q, busy_q;

    // Round chain: chain[0] is the register, chain[R] its next value in RUN.
    k_state chain [ROUNDS_PER_CYCLE + 1];
    assign chain[0] = perm_q;

    for (genvar k = 0; k < int'(ROUNDS_PER_CYCLE); k++) begin : g_round
        logic [RC_WIDTH-1:0] rc;

        keccak_rc_rom u_rc_rom (
            .idx_i (cnt_q + CNT_W'(k)),
            .rc_o  (rc)
        );

        keccak_round u_round (
            .state_i (chain[k]),
            .rc_i    (rc),
            .state_o (chain[k + 1])
        );
    end

    // Next-state and datapath select.
    always_comb begin
        state_d = state_q;
        perm_d  = perm_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    perm_d  = in_state_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                perm_d = chain[ROUNDS_PER_CYCLE];
                if ((cnt_q + STEP) == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + STEP;
                end
            end
            ST_DONE: begin
                if (out_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they track state_q exactly,
    // except in_ready which stays low for the reset cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            perm_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            perm_q      <= perm_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_state_o = perm_q;

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Self-checking bench for keccak_perm_ctrl (R=1 and R=4) and keccak_rc_rom.
module tb_keccak_perm_ctrl;
    import keccak_globals::*;

    logic   clk;
    logic   rst;
    logic   in_valid, in_ready, out_valid, out_ready, busy;
    k_state in_state, out_state;
    logic   r4_in_valid, r4_in_ready, r4_out_valid, r4_out_ready, r4_busy;
    k_state r4_in_state, r4_out_state;
    logic [4:0] rom_idx;
    logic [6:0] rom_rc;

    int n_checks = 0;
    int n_pass   = 0;

    keccak_perm_ctrl #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_state_i(in_state),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_state_o(out_state),
        .busy_o(busy)
    );

    keccak_perm_ctrl #(.ROUNDS_PER_CYCLE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(r4_in_valid), .in_ready_o(r4_in_ready), .in_state_i(r4_in_state),
        .out_valid_o(r4_out_valid), .out_ready_i(r4_out_ready), .out_state_o(r4_out_state),
        .busy_o(r4_busy)
    );

    keccak_rc_rom u_rom (.idx_i(rom_idx), .rc_o(rom_rc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Compares a whole state through the first lane that differs (lane 0 if none).
    task automatic chk_state(input string tag, input k_state act, input k_state exp);
        int yy = 0;
        int xx = 0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (act[y][x] !== exp[y][x] && act[yy][xx] === exp[yy][xx]) begin
                    yy = y;
                    xx = x;
                end
        chk($sformatf("%s[%0d][%0d]", tag, yy, xx), act[yy][xx], exp[yy][xx]);
    endtask

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        int m = n % 64;
        if (m == 0) return v;
        return (v << m) | (v >> (64 - m));
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], 1'b0} ^ (l[7] ? 8'h71 : 8'h00);
    endfunction

    // Compact round constant generated by the Keccak LFSR.
    function automatic logic [6:0] ref_rc(input int round);
        logic [7:0] l = 8'h01;
        logic [6:0] r = '0;
        for (int i = 0; i < 7 * round; i++) l = lfsr_step(l);
        for (int j = 0; j < 7; j++) begin
            r[j] = l[0];
            l = lfsr_step(l);
        end
        return r;
    endfunction

    // Reference Keccak-f[1600] on an A[x][y] lane array.
    function automatic k_state keccak_ref(input k_state s);
        logic [63:0] a [5][5];
        logic [63:0] b [5][5];
        logic [63:0] c [5];
        logic [63:0] d [5];
        int          rho [5][5];
        logic [7:0]  lfsr;
        logic [63:0] rc;
        int          px, py, tmp;
        k_state      res;

        rho[0][0] = 0;
        px = 1;
        py = 0;
        for (int t = 0; t < 24; t++) begin
            rho[px][py] = ((t + 1) * (t + 2) / 2) % 64;
            tmp = py;
            py  = (2 * px + 3 * py) % 5;
            px  = tmp;
        end

        for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) a[x][y] = s[y][x];

        lfsr = 8'h01;
        for (int r = 0; r < 24; r++) begin
            for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
            for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rol(c[(x + 1) % 5], 1);
            for (int x = 0; x < 5; x++) for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d[x];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    b[y][(2 * x + 3 * y) % 5] = rol(a[x][y], rho[x][y]);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    a[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
            rc = '0;
            for (int j = 0; j < 7; j++) begin
                if (lfsr[0]) rc[(1 << j) - 1] = 1'b1;
                lfsr = lfsr_step(lfsr);
            end
            a[0][0] = a[0][0] ^ rc;
        end

        for (int y = 0; y < 5; y++) for (int x = 0; x < 5; x++) res[y][x] = a[x][y];
        return res;
    endfunction

    function automatic k_state rand_state();
        logic [1599:0] v;
        for (int i = 0; i < 50; i++) v[i * 32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic accept(input k_state s);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_run", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_valid_low", 64'(out_valid), 64'd0);
        chk("hs_ready_high", 64'(in_ready), 64'd1);
    endtask

    initial begin
        k_state s, exp, held;
        int     lat, cyc, acc_n, out_n;
        int     acc_t [3];
        k_state bb [3];
        k_state exp_q [$];
        logic   stable_v, stable_s, ready_low, acc_now;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        r4_in_valid = 1'b0; r4_out_ready = 1'b0; r4_in_state = '0;
        rom_idx = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_state("rst_out_state", out_state, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        // Zero state, known first lane
        accept('0);
        wait_done(lat);
        chk("lat_r1_zero", 64'(lat), 64'd24);
        chk("busy_done", 64'(busy), 64'd0);
        chk("zero_lane00", out_state[0][0], 64'hF1258F7940E1DDE7);
        chk_state("zero_full", out_state, keccak_ref('0));
        handshake();

        // Backpressure with ignored input pulses
        s = rand_state();
        exp = keccak_ref(s);
        accept(s);
        wait_done(lat);
        chk("lat_r1_bp", 64'(lat), 64'd24);
        held = out_state;
        stable_v = 1'b1; stable_s = 1'b1; ready_low = 1'b1;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_state = rand_state();
            @(posedge clk); #1;
            if (out_valid !== 1'b1) stable_v = 1'b0;
            if (out_state !== held) stable_s = 1'b0;
            if (in_ready !== 1'b0) ready_low = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_valid_stable", 64'(stable_v), 64'd1);
        chk("bp_state_stable", 64'(stable_s), 64'd1);
        chk("bp_ready_low", 64'(ready_low), 64'd1);
        chk_state("bp_result", out_state, exp);
        handshake();

        // Reset in the middle of a run
        accept(rand_state());
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk_state("abort_state", out_state, '0);
        s = rand_state();
        exp = keccak_ref(s);
        accept(s);
        wait_done(lat);
        chk("lat_after_abort", 64'(lat), 64'd24);
        chk_state("after_abort", out_state, exp);
        handshake();

        // Back-to-back jobs with both handshakes held high
        for (int i = 0; i < 3; i++) bb[i] = rand_state();
        in_state = bb[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        cyc = 0; acc_n = 0; out_n = 0;
        while (out_n < 3 && cyc < 300) begin
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                if (exp_q.size() > 0) chk_state($sformatf("b2b_%0d", out_n), out_state, exp_q.pop_front());
                else chk("b2b_unexpected", 64'(out_valid), 64'd0);
                out_n++;
            end
            if (acc_now) begin
                acc_t[acc_n] = cyc;
                exp_q.push_back(keccak_ref(in_state));
                acc_n++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (acc_n < 3) in_state = bb[acc_n];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 64'(out_n), 64'd3);
        chk("b2b_period_1", 64'(acc_t[1] - acc_t[0]), 64'd26);
        chk("b2b_period_2", 64'(acc_t[2] - acc_t[1]), 64'd26);

        // Four rounds per cycle, same input also through the R=1 engine
        s = rand_state();
        exp = keccak_ref(s);
        chk("r4_ready", 64'(r4_in_ready), 64'd1);
        r4_in_state = s;
        r4_in_valid = 1'b1;
        @(posedge clk); #1;
        r4_in_valid = 1'b0;
        chk("r4_busy", 64'(r4_busy), 64'd1);
        lat = 0;
        while (!r4_out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat_r4", 64'(lat), 64'd6);
        chk_state("r4_result", r4_out_state, exp);
        r4_out_ready = 1'b1;
        @(posedge clk); #1;
        r4_out_ready = 1'b0;
        chk("r4_hs_valid_low", 64'(r4_out_valid), 64'd0);
        accept(s);
        wait_done(lat);
        chk_state("r1_same_input", out_state, exp);
        handshake();

        // Round-constant ROM sweep
        for (int i = 0; i < 32; i++) begin
            rom_idx = 5'(i);
            #1;
            chk($sformatf("rc_rom_%0d", i), 64'(rom_rc), (i < 24) ? 64'(ref_rc(i)) : 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
